// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: burst and response encodings, slave FSM states.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RESP,
    WR_DATA,
    WR_RESP,
    ERR_RESP
  } state_t;

  // Reserved burst type, beats wider than the 64-bit bus, and WRAP with a
  // beat count that is not 2/4/8/16 are all rejected.
  function automatic logic burst_legal(input logic [1:0] burst,
                                       input logic [2:0] size,
                                       input logic [7:0] len);
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst != 2'b11) && (size <= 3'd3) && ((burst != BURST_WRAP) || wrap_ok);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address for FIXED / INCR / WRAP bursts.
// Latency: combinational.
// Backpressure: none; caller decides when to take next_addr.
// Ports: addr/size/len/burst describe the current beat; next_addr is the following beat.
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [63:0] addr,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [63:0] next_addr
);

  logic [63:0] step;
  logic [63:0] incr_addr;
  logic [63:0] wrap_mask;

  always_comb begin
    step      = 64'd1 << size;
    incr_addr = addr + step;
    // Wrap window is (len+1) beats of (1<<size) bytes; the mask keeps the
    // offset inside the window while the upper bits stay at the window base.
    wrap_mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
    case (burst)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of a single-port 64-bit SRAM, one transaction at a time.
// Latency: AR/AW ready one cycle after valid seen in IDLE; reads 2 cycles/beat, writes 1 cycle/beat.
// Backpressure: holds R/B until rready/bready; W accepted whenever wvalid in the data phase.
// Ports: AXI AR/R/AW/W/B channels (ID width ID_W), SRAM ram_en/ram_we/ram_addr/ram_wdata/ram_rdata.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] arid,
  input  logic [63:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [63:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [63:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic            awvalid,
  output logic            awready,
  input  logic [63:0]     wdata,
  input  logic [7:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready,
  output logic            ram_en,
  output logic [7:0]      ram_we,
  output logic [63:0]     ram_addr,
  output logic [63:0]     ram_wdata,
  input  logic [63:0]     ram_rdata
);

  state_t          state_q;
  logic [ID_W-1:0] id_q;
  logic [63:0]     addr_q;
  logic [7:0]      len_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic [7:0]      beat_q;
  logic            err_q;
  logic            is_wr_q;
  logic            rr_ptr_q;   // 0: read wins a tie, 1: write wins a tie
  logic            ar_rdy_q;
  logic            aw_rdy_q;
  logic [63:0]     next_addr;
  logic            last_beat;

  assign last_beat = (beat_q == len_q);

  axi_burst_addr u_burst_addr (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      err_q    <= 1'b0;
      is_wr_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      ar_rdy_q <= 1'b0;
      aw_rdy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_rdy_q && arvalid) begin
            id_q     <= arid;
            addr_q   <= araddr;
            len_q    <= arlen;
            size_q   <= arsize;
            burst_q  <= arburst;
            beat_q   <= '0;
            err_q    <= 1'b0;
            is_wr_q  <= 1'b0;
            ar_rdy_q <= 1'b0;
            state_q  <= burst_legal(arburst, arsize, arlen) ? RD_REQ : ERR_RESP;
          end else if (aw_rdy_q && awvalid) begin
            id_q     <= awid;
            addr_q   <= awaddr;
            len_q    <= awlen;
            size_q   <= awsize;
            burst_q  <= awburst;
            beat_q   <= '0;
            err_q    <= !burst_legal(awburst, awsize, awlen);
            is_wr_q  <= 1'b1;
            aw_rdy_q <= 1'b0;
            state_q  <= burst_legal(awburst, awsize, awlen) ? WR_DATA : ERR_RESP;
          end else if (!ar_rdy_q && !aw_rdy_q) begin
            // Grant is registered so arready/awready never depend on valid
            // combinationally; AXI guarantees valid stays up until ready.
            if (arvalid && (!awvalid || !rr_ptr_q)) begin
              ar_rdy_q <= 1'b1;
              rr_ptr_q <= 1'b1;
            end else if (awvalid) begin
              aw_rdy_q <= 1'b1;
              rr_ptr_q <= 1'b0;
            end
          end
        end
        RD_REQ: state_q <= RD_RESP;
        RD_RESP: begin
          if (rready) begin
            addr_q  <= next_addr;
            beat_q  <= beat_q + 8'd1;
            state_q <= last_beat ? IDLE : RD_REQ;
          end
        end
        WR_DATA: begin
          if (wvalid) begin
            if (wlast != last_beat) err_q <= 1'b1;
            addr_q <= next_addr;
            beat_q <= beat_q + 8'd1;
            if (last_beat) state_q <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bready) state_q <= IDLE;
        end
        ERR_RESP: begin
          // Same beat count as a legal burst, but nothing reaches the SRAM.
          if (is_wr_q ? wvalid : rready) begin
            beat_q <= beat_q + 8'd1;
            if (last_beat) state_q <= is_wr_q ? WR_RESP : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic rd_beat;
  logic wr_phase;

  // rst gating keeps handshakes and SRAM strobes quiet during the reset cycle
  // itself, before the state register has returned to IDLE.
  assign rd_beat   = !rst && ((state_q == RD_RESP) || (state_q == ERR_RESP && !is_wr_q));
  assign wr_phase  = !rst && ((state_q == WR_DATA) || (state_q == ERR_RESP && is_wr_q));

  assign arready   = !rst && (state_q == IDLE) && ar_rdy_q;
  assign awready   = !rst && (state_q == IDLE) && aw_rdy_q;
  assign rvalid    = rd_beat;
  assign rid       = id_q;
  assign rdata     = (state_q == RD_RESP) ? ram_rdata : 64'd0;
  assign rresp     = (state_q == ERR_RESP) ? RESP_SLVERR : RESP_OKAY;
  assign rlast     = rd_beat && last_beat;
  assign wready    = wr_phase;
  assign bvalid    = !rst && (state_q == WR_RESP);
  assign bid       = id_q;
  assign bresp     = err_q ? RESP_SLVERR : RESP_OKAY;
  assign ram_en    = !rst && ((state_q == RD_REQ) || (state_q == WR_DATA && wvalid));
  assign ram_we    = (!rst && state_q == WR_DATA && wvalid) ? wstrb : 8'h00;
  assign ram_addr  = {addr_q[63:3], 3'b000};
  assign ram_wdata = wdata;

endmodule
